// File: rtl/sdu_ram_pkg.sv
// Shared definitions for the SDUltrasound accumulation RAM.
// Holds the zero-fill sweep state encodings and the external address width.
package sdu_ram_pkg;

  localparam int SDU_ADDR_W = 32;

  typedef enum logic [1:0] {
    INIT_IDLE  = 2'd0,
    INIT_SWEEP = 2'd1,
    INIT_DONE  = 2'd2
  } init_state_e;

endpackage

// File: rtl/sdu_ram_init.sv
// Zero-fill sequencer: after each reset release, walks every address once
// and requests a zero write, holding init_busy high for the whole sweep.
module sdu_ram_init
  import sdu_ram_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          init_busy,
  output logic [AW-1:0] init_addr
);

  init_state_e   state, state_next;
  logic [AW-1:0] ptr, ptr_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= INIT_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The last location is written on the same edge that moves the FSM to DONE.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      INIT_IDLE: begin
        state_next = INIT_SWEEP;
        ptr_next   = '0;
      end
      INIT_SWEEP: begin
        ptr_next = ptr + AW'(1);
        if (ptr == {AW{1'b1}}) state_next = INIT_DONE;
      end
      default: ;
    endcase
  end

  assign init_busy = (state == INIT_SWEEP);
  assign init_addr = ptr;

endmodule

// File: rtl/sdu_ram.sv
// Simple dual-port accumulation RAM with combinational read, used for
// single-cycle read-modify-write in the receive path; optional zero-fill.
module sdu_ram
  import sdu_ram_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 16,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SDU_ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]         rd_data,
  input  logic [SDU_ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  wr_en,
  output logic                  init_busy
);

  reg [DW-1:0] mem [0:2**AW-1];

  logic [AW-1:0] sweep_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          unused_addr_bits;

  generate
    if (INIT_ZERO) begin : g_init
      sdu_ram_init #(
        .AW (AW)
      ) u_init (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_busy (init_busy),
        .init_addr (sweep_addr)
      );
    end else begin : g_no_init
      assign init_busy  = 1'b0;
      assign sweep_addr = '0;
    end
  endgenerate

  // The sweep owns the write port while busy; user writes are dropped.
  assign mem_we    = init_busy ? 1'b1       : wr_en;
  assign mem_waddr = init_busy ? sweep_addr : wr_addr[AW-1:0];
  assign mem_wdata = init_busy ? '0         : wr_data;

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data = mem[rd_addr[AW-1:0]];

  assign unused_addr_bits = ^{rd_addr[SDU_ADDR_W-1:AW], wr_addr[SDU_ADDR_W-1:AW]};

endmodule

// File: tb/tb_sdu_ram.sv
// Directed testbench for sdu_ram: a default instance without zero-fill
// and a small AW=4 instance with the zero-fill sweep enabled.
module tb_sdu_ram;

  logic        clk;
  logic        reset_n;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
  logic        wr_en, init_busy;

  logic        reset_n_b;
  logic [31:0] rd_addr_b, wr_addr_b, wr_data_b, rd_data_b;
  logic        wr_en_b, init_busy_b;

  int assert_count = 0;
  int fail_count   = 0;

  sdu_ram #(.DW(32), .AW(16), .INIT_ZERO(1'b0)) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .init_busy (init_busy)
  );

  sdu_ram #(.DW(32), .AW(4), .INIT_ZERO(1'b1)) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n_b),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .wr_addr   (wr_addr_b),
    .wr_data   (wr_data_b),
    .wr_en     (wr_en_b),
    .init_busy (init_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic readA(input logic [31:0] addr, output logic [31:0] data);
    rd_addr = addr;
    #1;
    data = rd_data;
  endtask

  // Counts cycles with init_busy_b high after release; bounded wait.
  task automatic measureSweep(input int stop_after, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (init_busy_b) busy_cycles++;
      else if (busy_cycles > 0) break;
      if (stop_after > 0 && busy_cycles == stop_after) break;
    end
    wr_en_b = 1'b0;
  endtask

  initial begin
    logic [31:0] val;
    int          cycles;

    reset_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
    reset_n_b = 1'b0; rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; wr_en_b = 1'b0;
    repeat (3) tick();
    checkOutput("reset_busy_a", {63'd0, init_busy}, 64'd0);
    checkOutput("reset_busy_b", {63'd0, init_busy_b}, 64'd0);
    reset_n = 1'b1;
    tick();

    applyStimulus(32'd0,     32'h0000_1234);
    applyStimulus(32'd1,     32'hFFFF_FFFE);
    applyStimulus(32'd65535, 32'h8000_0000);
    readA(32'd0, val);     checkOutput("wr_rd_0",     {32'd0, val}, 64'h0000_1234);
    readA(32'd1, val);     checkOutput("wr_rd_1",     {32'd0, val}, 64'hFFFF_FFFE);
    readA(32'd65535, val); checkOutput("wr_rd_65535", {32'd0, val}, 64'h8000_0000);

    for (int k = 0; k < 8; k++) applyStimulus(k, 32'd0);
    for (int pass = 0; pass < 3; pass++) begin
      for (int k = 0; k < 8; k++) begin
        rd_addr = k;
        wr_addr = k;
        #1;
        wr_data = rd_data + 32'd5;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
      end
    end
    for (int k = 0; k < 8; k++) begin
      readA(k, val);
      checkOutput($sformatf("rmw_%0d", k), {32'd0, val}, 64'd15);
    end

    applyStimulus(32'd3, 32'd7);
    rd_addr = 32'd3; wr_addr = 32'd3; wr_data = 32'd9; wr_en = 1'b1;
    #1;
    checkOutput("collide_before", {32'd0, rd_data}, 64'd7);
    tick();
    wr_en = 1'b0;
    checkOutput("collide_after", {32'd0, rd_data}, 64'd9);

    applyStimulus(32'h0001_0002, 32'h0000_00AA);
    readA(32'h0000_0002, val); checkOutput("alias_low",  {32'd0, val}, 64'hAA);
    readA(32'hFFFF_0002, val); checkOutput("alias_high", {32'd0, val}, 64'hAA);

    reset_n = 1'b0;
    wr_addr = 32'd5; wr_data = 32'h55; wr_en = 1'b1;
    repeat (2) tick();
    readA(32'd5, val); checkOutput("reset_nowrite", {32'd0, val}, 64'd15);
    wr_en = 1'b0;
    reset_n = 1'b1;
    tick();
    readA(32'd5, val);     checkOutput("post_reset_5",     {32'd0, val}, 64'd15);
    readA(32'd1, val);     checkOutput("post_reset_1",     {32'd0, val}, 64'd15);
    readA(32'd65535, val); checkOutput("post_reset_65535", {32'd0, val}, 64'h8000_0000);

    // Zero-fill instance: full sweep while a user write is attempted.
    wr_addr_b = 32'd3; wr_data_b = 32'hDEAD; wr_en_b = 1'b1;
    reset_n_b = 1'b1;
    measureSweep(0, cycles);
    checkOutput("sweep_cycles", cycles, 64'd16);
    checkOutput("sweep_done_busy", {63'd0, init_busy_b}, 64'd0);
    for (int k = 0; k < 16; k++) begin
      rd_addr_b = k;
      #1;
      checkOutput($sformatf("zero_%0d", k), {32'd0, rd_data_b}, 64'd0);
    end

    wr_addr_b = 32'd4; wr_data_b = 32'h77; wr_en_b = 1'b1;
    tick();
    wr_en_b = 1'b0;
    rd_addr_b = 32'd4; #1;
    checkOutput("b_write_after_done", {32'd0, rd_data_b}, 64'h77);

    // Abort mid-sweep, then confirm a full restart from address 0.
    reset_n_b = 1'b0;
    tick();
    reset_n_b = 1'b1;
    measureSweep(5, cycles);
    checkOutput("partial_sweep", cycles, 64'd5);
    reset_n_b = 1'b0;
    tick();
    checkOutput("abort_busy", {63'd0, init_busy_b}, 64'd0);
    reset_n_b = 1'b1;
    measureSweep(0, cycles);
    checkOutput("restart_cycles", cycles, 64'd16);
    rd_addr_b = 32'd4; #1;
    checkOutput("restart_cleared", {32'd0, rd_data_b}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
